// File: rtl/cam_cfg_sequencer.sv
// Camera configuration ROM reader: walks ROM words and issues one SCCB register write per entry.
// Optional SCCB completion timeout is compiled in with `define CAM_CFG_TIMEOUT_EN.
module cam_cfg_sequencer #(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned DELAY_MS       = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        sccb_req,
  input  logic        sccb_ready,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_data,
  input  logic        sccb_done,
  output logic        busy,
  output logic        cfg_done,
  output logic        err
);

  localparam int unsigned DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
  localparam int unsigned DlyW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int unsigned DlyLoadInt = (DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0;
  localparam logic [DlyW-1:0] DlyLoad = DlyW'(DlyLoadInt);

  localparam logic [15:0] EndWord   = 16'hFFFF;
  localparam logic [15:0] DelayWord = 16'hFFF0;

  if (DELAY_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $fatal(1, "cam_cfg_sequencer: DELAY_CYCLES and TIMEOUT_CYCLES must be non-zero");
  end

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StIssue, StWaitDone, StDelay, StNext, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      rom_addr_q, rom_addr_d;
  logic            sccb_req_q, sccb_req_d;
  logic [7:0]      sccb_reg_q, sccb_reg_d;
  logic [7:0]      sccb_data_q, sccb_data_d;
  logic            busy_q, busy_d;
  logic            cfg_done_q, cfg_done_d;
  logic            err_q, err_d;
  logic [DlyW-1:0] dly_cnt_q, dly_cnt_d;

`ifdef CAM_CFG_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    sccb_req_d  = sccb_req_q;
    sccb_reg_d  = sccb_reg_q;
    sccb_data_d = sccb_data_q;
    busy_d      = busy_q;
    cfg_done_d  = cfg_done_q;
    err_d       = err_q;
    dly_cnt_d   = dly_cnt_q;
`ifdef CAM_CFG_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          rom_addr_d = 8'h00;
          busy_d     = 1'b1;
          cfg_done_d = 1'b0;
          err_d      = 1'b0;
          state_d    = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (rom_dout == EndWord) begin
          busy_d     = 1'b0;
          cfg_done_d = 1'b1;
          state_d    = StDone;
        end else if (rom_dout == DelayWord) begin
          dly_cnt_d = DlyLoad;
          state_d   = StDelay;
        end else begin
          sccb_reg_d  = rom_dout[15:8];
          sccb_data_d = rom_dout[7:0];
          sccb_req_d  = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (sccb_ready) begin
          sccb_req_d = 1'b0;
          state_d    = StWaitDone;
`ifdef CAM_CFG_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
      StWaitDone: begin
        if (sccb_done) begin
          state_d = StNext;
        end
`ifdef CAM_CFG_TIMEOUT_EN
        else if (to_cnt_q == ToLast) begin
          err_d      = 1'b1;
          busy_d     = 1'b0;
          cfg_done_d = 1'b1;
          state_d    = StDone;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      StDelay: begin
        if (dly_cnt_q == '0) begin
          state_d = StNext;
        end else begin
          dly_cnt_d = dly_cnt_q - 1'b1;
        end
      end
      StNext: begin
        // Stop at the top of the ROM rather than wrapping back to entry 0.
        if (rom_addr_q == 8'hFF) begin
          busy_d     = 1'b0;
          cfg_done_d = 1'b1;
          state_d    = StDone;
        end else begin
          rom_addr_d = rom_addr_q + 8'h01;
          state_d    = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rom_addr_q  <= 8'h00;
      sccb_req_q  <= 1'b0;
      sccb_reg_q  <= 8'h00;
      sccb_data_q <= 8'h00;
      busy_q      <= 1'b0;
      cfg_done_q  <= 1'b0;
      err_q       <= 1'b0;
      dly_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      sccb_req_q  <= sccb_req_d;
      sccb_reg_q  <= sccb_reg_d;
      sccb_data_q <= sccb_data_d;
      busy_q      <= busy_d;
      cfg_done_q  <= cfg_done_d;
      err_q       <= err_d;
      dly_cnt_q   <= dly_cnt_d;
    end
  end

`ifdef CAM_CFG_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rom_addr  = rom_addr_q;
  assign sccb_req  = sccb_req_q;
  assign sccb_reg  = sccb_reg_q;
  assign sccb_data = sccb_data_q;
  assign busy      = busy_q;
  assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer: ROM model plus a simple SCCB master model.
module tb_cam_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        sccb_req;
  logic        sccb_ready = 1'b1;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_data;
  logic        sccb_done;
  logic        busy;
  logic        cfg_done;
  logic        err;

  logic [15:0] rom [256];
  logic [15:0] wr_log [$];
  int          done_lat = 3;
  bit          done_en = 1'b1;
  int          done_cnt = 0;
  logic        done_m = 1'b0;
  logic        spur_done = 1'b0;
  int          req_cycles = 0;

  int n_checks = 0;
  int n_pass = 0;

  cam_cfg_sequencer #(
    .CLK_FREQ_HZ   (1_000_000),
    .DELAY_MS      (1),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .sccb_req  (sccb_req),
    .sccb_ready(sccb_ready),
    .sccb_reg  (sccb_reg),
    .sccb_data (sccb_data),
    .sccb_done (sccb_done),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign rom_dout  = rom[rom_addr];
  assign sccb_done = done_m | spur_done;

  // Master model: logs each accepted write and pulses done done_lat cycles later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_cnt = 0;
      done_m <= 1'b0;
    end else begin
      done_m <= 1'b0;
      if (done_cnt > 0) begin
        done_cnt = done_cnt - 1;
        if (done_cnt == 0) done_m <= 1'b1;
      end
      if (sccb_req && sccb_ready) begin
        wr_log.push_back({sccb_reg, sccb_data});
        if (done_en) done_cnt = done_lat;
      end
    end
  end

  always @(negedge clk) if (sccb_req) req_cycles++;

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_cfg_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (cfg_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    fill_rom(16'hFFFF);
    repeat (2) @(negedge clk);
    n_checks++; if (rom_addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", rom_addr); else n_pass++;
    n_checks++; if (sccb_req !== 1'b0) $display("FAIL rst_req: got %b want 0", sccb_req); else n_pass++;
    n_checks++; if ({sccb_reg, sccb_data} !== 16'h0000) $display("FAIL rst_regdata: got %h want 0000", {sccb_reg, sccb_data}); else n_pass++;
    n_checks++; if ({busy, cfg_done, err} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {busy, cfg_done, err}); else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    fill_rom(16'hFFFF);
    rom[0] = 16'h1280;
    rom[1] = 16'h1214;
    done_lat = 3;
    sccb_ready = 1'b1;
    wr_log.delete();
    pulse_start();
    n_checks++; if (busy !== 1'b1 || cfg_done !== 1'b0) $display("FAIL basic_busy: got busy=%b done=%b want 1/0", busy, cfg_done); else n_pass++;
    wait_cfg_done(200, ok);
    n_checks++; if (!ok) $display("FAIL basic_term: got no cfg_done want cfg_done within 200 cycles"); else n_pass++;
    n_checks++; if (wr_log.size() != 2) $display("FAIL basic_count: got %0d want 2", wr_log.size()); else n_pass++;
    n_checks++; if (wr_log.size() < 2 || wr_log[0] !== 16'h1280 || wr_log[1] !== 16'h1214)
      $display("FAIL basic_writes: got %p want 1280,1214", wr_log); else n_pass++;
    n_checks++; if (busy !== 1'b0 || rom_addr !== 8'h02) $display("FAIL basic_end: got busy=%b addr=%h want 0/02", busy, rom_addr); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_delay();
    int cnt = 0;
    fill_rom(16'hFFFF);
    rom[0] = 16'hFFF0;
    req_cycles = 0;
    wr_log.delete();
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      if (cfg_done) break;
      if (busy) cnt++;
      @(negedge clk);
    end
    // FETCH, DECODE, 1000 x DELAY, NEXT, FETCH, DECODE
    n_checks++; if (cnt != 1005) $display("FAIL delay_busy: got %0d want 1005", cnt); else n_pass++;
    n_checks++; if (req_cycles != 0 || wr_log.size() != 0) $display("FAIL delay_noreq: got req=%0d wr=%0d want 0/0", req_cycles, wr_log.size()); else n_pass++;
    n_checks++; if (cfg_done !== 1'b1) $display("FAIL delay_done: got %b want 1", cfg_done); else n_pass++;
  endtask

  task automatic test_ready_stall();
    bit ok;
    bit stable = 1'b1;
    fill_rom(16'hFFFF);
    rom[0] = 16'h3A55;
    sccb_ready = 1'b0;
    wr_log.delete();
    pulse_start();
    for (int i = 0; i < 20 && !sccb_req; i++) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (sccb_req !== 1'b1 || sccb_reg !== 8'h3A || sccb_data !== 8'h55) stable = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (!stable) $display("FAIL stall_hold: got unstable req/reg/data want stable 1/3A/55"); else n_pass++;
    n_checks++; if (wr_log.size() != 0) $display("FAIL stall_nowr: got %0d want 0", wr_log.size()); else n_pass++;
    sccb_ready = 1'b1;
    wait_cfg_done(100, ok);
    n_checks++; if (!ok || wr_log.size() != 1 || wr_log[0] !== 16'h3A55)
      $display("FAIL stall_xfer: got ok=%b n=%0d want 1 write of 3A55", ok, wr_log.size()); else n_pass++;
  endtask

  task automatic test_disturb();
    bit ok;
    fill_rom(16'hFFFF);
    rom[0] = 16'h1280;
    rom[1] = 16'h1214;
    rom[2] = 16'h1111;
    sccb_ready = 1'b0;
    wr_log.delete();
    pulse_start();
    for (int i = 0; i < 20 && !sccb_req; i++) @(negedge clk);
    @(negedge clk) begin spur_done = 1'b1; start = 1'b1; end
    @(negedge clk) begin spur_done = 1'b0; start = 1'b0; end
    sccb_ready = 1'b1;
    wait_cfg_done(200, ok);
    n_checks++; if (!ok || wr_log.size() != 3) $display("FAIL disturb_count: got ok=%b n=%0d want 3", ok, wr_log.size()); else n_pass++;
    n_checks++; if (wr_log.size() < 3 || wr_log[0] !== 16'h1280 || wr_log[1] !== 16'h1214 || wr_log[2] !== 16'h1111)
      $display("FAIL disturb_seq: got %p want 1280,1214,1111", wr_log); else n_pass++;
    n_checks++; if (rom_addr !== 8'h03) $display("FAIL disturb_addr: got %h want 03", rom_addr); else n_pass++;
  endtask

  task automatic test_full_rom();
    bit ok;
    bit match = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = {8'(i), 8'(i) ^ 8'h5A};
    done_lat = 1;
    sccb_ready = 1'b1;
    wr_log.delete();
    pulse_start();
    wait_cfg_done(3000, ok);
    n_checks++; if (!ok || wr_log.size() != 256) $display("FAIL full_count: got ok=%b n=%0d want 256", ok, wr_log.size()); else n_pass++;
    for (int i = 0; i < 256 && i < wr_log.size(); i++)
      if (wr_log[i] !== {8'(i), 8'(i) ^ 8'h5A}) match = 1'b0;
    n_checks++; if (!match) $display("FAIL full_data: got mismatching write contents want {i, i^5A}"); else n_pass++;
    n_checks++; if (rom_addr !== 8'hFF || busy !== 1'b0) $display("FAIL full_addr: got addr=%h busy=%b want FF/0", rom_addr, busy); else n_pass++;
  endtask

  task automatic test_reset_midpass();
    bit ok;
    wr_log.delete();
    pulse_start();
    for (int i = 0; i < 1000 && wr_log.size() < 40; i++) @(negedge clk);
    n_checks++; if (wr_log.size() != 40) $display("FAIL mid_reach: got %0d want 40", wr_log.size()); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({rom_addr, sccb_req, sccb_reg, sccb_data, busy, cfg_done, err} !== 28'h0)
      $display("FAIL mid_rst: got addr=%h req=%b rd=%h%h b/d/e=%b%b%b want all 0",
               rom_addr, sccb_req, sccb_reg, sccb_data, busy, cfg_done, err); else n_pass++;
    @(negedge clk) reset_n = 1'b1;
    wr_log.delete();
    pulse_start();
    for (int i = 0; i < 50 && wr_log.size() < 1; i++) @(negedge clk);
    n_checks++; if (wr_log.size() < 1 || wr_log[0] !== 16'h005A) $display("FAIL mid_restart: got n=%0d first=%h want 005A", wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 16'h0); else n_pass++;
    wait_cfg_done(3000, ok);
    n_checks++; if (!ok || wr_log.size() != 256) $display("FAIL mid_finish: got ok=%b n=%0d want 256", ok, wr_log.size()); else n_pass++;
  endtask

`ifdef CAM_CFG_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int cnt = 0;
    fill_rom(16'hFFFF);
    rom[0] = 16'h1280;
    done_en = 1'b0;
    sccb_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 20 && !sccb_req; i++) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 500; i++) begin
      if (cfg_done) break;
      cnt++;
      @(negedge clk);
    end
    n_checks++; if (cnt != 100) $display("FAIL to_cycles: got %0d want 100", cnt); else n_pass++;
    n_checks++; if ({err, cfg_done, busy} !== 3'b110) $display("FAIL to_flags: got %b want 110", {err, cfg_done, busy}); else n_pass++;
    done_en = 1'b1;
    pulse_start();
    n_checks++; if (err !== 1'b0) $display("FAIL to_clear: got %b want 0", err); else n_pass++;
    wait_cfg_done(200, ok);
    n_checks++; if (!ok || err !== 1'b0) $display("FAIL to_rerun: got ok=%b err=%b want 1/0", ok, err); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_ready_stall();
    test_disturb();
    test_full_rom();
    test_reset_midpass();
`ifdef CAM_CFG_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
